rv32i_fetch_stage: RTL and testbench

//  Instruction fetch stage plus IF/ID pipeline register; feeds rv32i_decoder's i_inst.
//  - Generates PC and issues in-order reads to instruction memory over a req/ready + rvalid interface.
//  - Buffers returned words in a small FIFO; presents one instruction per cycle with its PC.
//  - Supports hazard stall, branch/jump redirect, and discard of stale in-flight responses.

---
 rtl/rv32i_fetch_stage.sv | 110 +++++++++++
 tb/tb_rv32i_fetch_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rv32i_fetch_stage.sv
// rv32i_fetch_stage: PC generation, in-order imem reads, response FIFO and IF/ID register.
// Optional feature macro RV32I_FETCH_MISALIGN_EN adds o_misaligned for unaligned redirect targets.
module rv32i_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
`ifdef RV32I_FETCH_MISALIGN_EN
    output logic        o_misaligned,
`endif
    output logic        o_valid
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   fetch_pc, deq_pc, redir_pc;
    logic [CW-1:0] outstanding, drop_cnt, fifo_count;
    logic [CW:0]   credit_used;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic          accept, resp, push, pop, mis_hold;

`ifdef RV32I_FETCH_MISALIGN_EN
    logic mis_q;
    assign redir_pc     = i_redirect_pc;
    assign mis_hold     = mis_q;
    assign o_misaligned = mis_q;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) mis_q <= 1'b0;
        else if (i_redirect) mis_q <= |i_redirect_pc[1:0];
`else
    logic unused_pc_bits;
    assign unused_pc_bits = ^i_redirect_pc[1:0];
    assign redir_pc       = {i_redirect_pc[31:2], 2'b00};
    assign mis_hold       = 1'b0;
`endif

    assign o_imem_addr = fetch_pc;

    // Credit counts both in-flight reads and buffered words, so the FIFO can never overflow.
    always_comb begin
        credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
        o_imem_req  = !i_rst && !i_redirect && !mis_hold && credit_used < (CW+1)'(FIFO_DEPTH);
        accept      = o_imem_req && i_imem_ready;
        resp        = i_imem_rvalid && outstanding != '0;
        push        = resp && drop_cnt == '0 && !i_redirect;
        pop         = !i_redirect && !i_stall && fifo_count != '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_pc    <= RESET_PC;
            deq_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_valid     <= 1'b0;
            o_inst      <= NOP_INST;
            o_pc        <= RESET_PC;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(resp);
            if (i_redirect) begin
                // Every read still in flight after this edge belongs to the old path.
                fetch_pc   <= redir_pc;
                deq_pc     <= redir_pc;
                drop_cnt   <= outstanding - CW'(resp);
                fifo_count <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                o_valid    <= 1'b0;
                o_inst     <= NOP_INST;
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'd4;
                if (resp && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
                if (pop) begin
                    o_inst  <= fifo_mem[rd_ptr];
                    o_pc    <= deq_pc;
                    o_valid <= 1'b1;
                    deq_pc  <= deq_pc + 32'd4;
                end else if (!i_stall) begin
                    o_valid <= 1'b0;
                    o_inst  <= NOP_INST;
                end
            end
        end
    end

    always_ff @(posedge i_clk)
        if (push) fifo_mem[wr_ptr] <= i_imem_rdata;

    rvalid_needs_outstanding: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_imem_rvalid && outstanding == '0));
endmodule

// File: tb/tb_rv32i_fetch_stage.sv
// tb_rv32i_fetch_stage: randomized fetch-stage bench with a transaction-level memory and IF/ID model.
module tb_rv32i_fetch_stage;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DEPTH = 2;

    logic        i_clk = 1'b0;
    logic        i_rst, i_imem_ready, i_imem_rvalid, i_stall, i_redirect;
    logic [31:0] i_imem_rdata, i_redirect_pc;
    logic        o_imem_req, o_valid;
    logic [31:0] o_imem_addr, o_inst, o_pc;
`ifdef RV32I_FETCH_MISALIGN_EN
    logic        o_misaligned;
`endif

    always #5 i_clk = ~i_clk;

    rv32i_fetch_stage dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ready(i_imem_ready), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .i_stall(i_stall), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_inst(o_inst), .o_pc(o_pc),
`ifdef RV32I_FETCH_MISALIGN_EN
        .o_misaligned(o_misaligned),
`endif
        .o_valid(o_valid)
    );

    typedef struct { logic [31:0] addr; int epoch; int due; } rd_t;
    rd_t         pend[$];
    logic [31:0] fq[$];
    int          epoch, cyc, lat_lo, lat_hi, rdy_pct, checks, fails;
    logic [31:0] m_fetch, m_inst, m_pc;
    logic        m_valid, m_mis;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        fq.delete();
        epoch++;
        m_fetch = 32'h0;
        m_inst  = NOP;
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_mis   = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
        i_imem_ready = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
        model_reset();
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_inst", o_inst, NOP);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_req", o_imem_req, 1'b0);
        i_rst = 1'b0;
    endtask

    // One clock: drive inputs, check issue side, advance the model, check the IF/ID register.
    task automatic step(input logic stall, input logic redir, input logic [31:0] rpc);
        logic        rv, rdy, exp_req;
        logic [31:0] ra, hd;
        int          ep;
        rdy = $urandom_range(99) < rdy_pct;
        rv  = pend.size() > 0 && pend[0].due <= cyc;
        ra  = rv ? pend[0].addr : 32'h0;
        ep  = rv ? pend[0].epoch : -1;
        i_stall = stall; i_redirect = redir; i_redirect_pc = rpc; i_imem_ready = rdy;
        i_imem_rvalid = rv;
        i_imem_rdata  = rv ? word_of(ra) : $urandom;
        exp_req = !redir && !m_mis && (pend.size() + fq.size()) < DEPTH;
        #1;
        chk("req", o_imem_req, exp_req);
        if (exp_req) chk("addr", o_imem_addr, m_fetch);
        if (rv) void'(pend.pop_front());
        if (redir) begin
            epoch++;
            fq.delete();
            m_valid = 1'b0;
            m_inst  = NOP;
`ifdef RV32I_FETCH_MISALIGN_EN
            m_fetch = rpc;
            m_mis   = |rpc[1:0];
`else
            m_fetch = {rpc[31:2], 2'b00};
`endif
        end else begin
            if (!stall) begin
                if (fq.size() > 0) begin
                    hd = fq.pop_front();
                    m_valid = 1'b1; m_pc = hd; m_inst = word_of(hd);
                end else begin
                    m_valid = 1'b0; m_inst = NOP;
                end
            end
            if (rv && ep == epoch) fq.push_back(ra);
            if (exp_req && rdy) begin
                pend.push_back('{addr: m_fetch, epoch: epoch, due: cyc + $urandom_range(lat_hi, lat_lo)});
                m_fetch += 32'd4;
            end
        end
        @(posedge i_clk); #1;
        cyc++;
        chk("valid", o_valid, m_valid);
        chk("inst", o_inst, m_inst);
        chk("pc", o_pc, m_pc);
`ifdef RV32I_FETCH_MISALIGN_EN
        chk("misaligned", o_misaligned, m_mis);
`endif
    endtask

    task automatic run(input int n, input int stall_pct, input int redir_pct);
        logic [31:0] t;
        logic        r;
        for (int i = 0; i < n; i++) begin
            t = $urandom;
            r = $urandom_range(99) < redir_pct;
`ifdef RV32I_FETCH_MISALIGN_EN
            if ($urandom_range(9) != 0) t[1:0] = 2'b00;
`endif
            step($urandom_range(99) < stall_pct, r, t);
        end
    endtask

    initial begin
        checks = 0; fails = 0; epoch = 0; cyc = 0;
        lat_lo = 1; lat_hi = 1; rdy_pct = 100;
        do_reset();
        run(12, 0, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, $urandom);
        run(8, 0, 0);
        lat_lo = 1; lat_hi = 3; rdy_pct = 70;
        run(40, 20, 0);
        lat_lo = 3; lat_hi = 3; rdy_pct = 100;
        run(4, 0, 0);
        step(1'b0, 1'b1, 32'h0000_0100);
        run(10, 0, 0);
        step(1'b1, 1'b1, 32'h0000_0040);
        run(8, 0, 0);
        lat_lo = 1; lat_hi = 1; rdy_pct = 0;
        run(4, 0, 0);
        rdy_pct = 100;
        step(1'b0, 1'b1, 32'hFFFF_FFF8);
        run(8, 0, 0);
        step(1'b0, 1'b1, 32'h0000_0203);
        run(4, 0, 0);
        lat_lo = 1; lat_hi = 3; rdy_pct = 75;
        run(300, 15, 5);
        i_rst = 1'b1;
        #1;
        chk("async_rst_valid", o_valid, 1'b0);
        chk("async_rst_inst", o_inst, NOP);
        do_reset();
        run(20, 10, 0);
`ifdef RV32I_FETCH_MISALIGN_EN
        step(1'b0, 1'b1, 32'h0000_0102);
        run(3, 0, 0);
        step(1'b0, 1'b1, 32'h0000_0200);
        run(8, 0, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
